// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS subset: opcodes, functs,
// ALU control codes and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  localparam logic [5:0] FnAdd = 6'd32;
  localparam logic [5:0] FnSub = 6'd34;
  localparam logic [5:0] FnAnd = 6'd36;
  localparam logic [5:0] FnOr  = 6'd37;
  localparam logic [5:0] FnSlt = 6'd42;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_we;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_single_if.sv
// Word-wide bus between the core and a byte-array memory.
interface mips_single_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_mem.sv
// Byte-array memory with little-endian word access; every byte address wraps
// modulo Bytes, so unaligned and wrap-around words are allowed.
module mips_mem #(
  parameter int unsigned Bytes = 128
) (
  input logic           clk,
  input logic           rst,
  mips_single_if.slave  bus
);

  localparam int unsigned Aw = $clog2(Bytes);

  logic [7:0]    mem_array [Bytes];
  logic [Aw-1:0] idx [4];

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = Aw'(bus.addr + 32'(k));
      bus.rdata[8*k +: 8] = mem_array[idx[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.we) begin
      for (int k = 0; k < 4; k++) begin
        mem_array[idx[k]] <= bus.wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file, two combinational read ports and one write port.
// Register $0 reads as zero and ignores writes.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] file_array [32];

  // Contents are preloaded externally; no reset clear.
  always_ff @(posedge clk) begin
    if (!rst && we && (wa != 5'd0)) begin
      file_array[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : file_array[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : file_array[ra2];

endmodule

// File: rtl/mips_single.sv
// Single-cycle MIPS subset core (ADD/SUB/AND/OR/SLT, LW, SW, BEQ, J).
// Decode and ALU live here; register file and memories are sub-modules.
module mips_single
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 128,
  parameter int unsigned DMEM_BYTES = 128
) (
  input logic clk,
  input logic rst
);

  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_ext, rs_val, rt_val, alu_b, alu_y, rfile_wd;
  ctrl_t       ctrl;
  logic        unused_shamt;

  mips_single_if imem_bus ();
  mips_single_if dmem_bus ();

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign target       = instr[25:0];
  assign imm_ext      = sign_ext16(imm);
  assign unused_shamt = ^instr[10:6];

  // Unsupported opcodes/functs fall through with all enables low.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = AluAdd;
    case (opcode)
      OpRtype: begin
        ctrl.reg_dst_rd = 1'b1;
        case (funct)
          FnAdd:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = AluAdd; end
          FnSub:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = AluSub; end
          FnAnd:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = AluAnd; end
          FnOr:    begin ctrl.reg_we = 1'b1; ctrl.alu_op = AluOr;  end
          FnSlt:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = AluSlt; end
          default: ;
        endcase
      end
      OpLw: begin
        ctrl.reg_we      = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpSw: begin
        ctrl.mem_we      = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpBeq:   ctrl.branch = 1'b1;
      OpJ:     ctrl.jump   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = rs_val + alu_b;
    case (ctrl.alu_op)
      AluAdd:  alu_y = rs_val + alu_b;
      AluSub:  alu_y = rs_val - alu_b;
      AluAnd:  alu_y = rs_val & alu_b;
      AluOr:   alu_y = rs_val | alu_b;
      AluSlt:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_y = rs_val + alu_b;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jump) begin
      pc_next = {pc_plus4[31:28], target, 2'b00};
    end else if (ctrl.branch && (rs_val == rt_val)) begin
      pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  assign wa       = ctrl.reg_dst_rd ? rd : rt;
  assign rfile_wd = ctrl.mem_to_reg ? dmem_bus.rdata : alu_y;

  assign imem_bus.addr  = pc;
  assign imem_bus.wdata = '0;
  assign imem_bus.we    = 1'b0;
  assign instr          = imem_bus.rdata;

  assign dmem_bus.addr  = alu_y;
  assign dmem_bus.wdata = rt_val;
  assign dmem_bus.we    = ctrl.mem_we;

  reg_file RegFile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wa),
    .we  (ctrl.reg_we),
    .wd  (rfile_wd),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  mips_mem #(
    .Bytes (IMEM_BYTES)
  ) InstrMem (
    .clk (clk),
    .rst (rst),
    .bus (imem_bus)
  );

  mips_mem #(
    .Bytes (DMEM_BYTES)
  ) DatMem (
    .clk (clk),
    .rst (rst),
    .bus (dmem_bus)
  );

endmodule

// File: tb/tb_mips_single.sv
// Bench for mips_single: an ISA-level interpreter tracks architectural state
// and is compared against the DUT every cycle, plus literal spot checks.
module tb_mips_single;

  localparam int unsigned IMEM = 128;
  localparam int unsigned DMEM = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 1'b0;

  logic [7:0]  m_imem [IMEM];
  logic [7:0]  m_dmem [DMEM];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc = 32'd0;

  logic [31:0] pc_tab [10] = '{32'h04, 32'h08, 32'h10, 32'h1C, 32'h20,
                               32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};

  mips_single #(
    .IMEM_BYTES (IMEM),
    .DMEM_BYTES (DMEM)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {m_imem[(a + 3) % IMEM], m_imem[(a + 2) % IMEM],
            m_imem[(a + 1) % IMEM], m_imem[a % IMEM]};
  endfunction

  function automatic logic [31:0] dmem_word(input logic [31:0] a);
    return {m_dmem[(a + 3) % DMEM], m_dmem[(a + 2) % DMEM],
            m_dmem[(a + 1) % DMEM], m_dmem[a % DMEM]};
  endfunction

  // What the instruction at m_pc does, in ISA terms.
  task automatic model_eval(output bit wr, output logic [4:0] dst, output logic [31:0] wd,
                            output bit st, output logic [31:0] addr, output logic [31:0] data,
                            output logic [31:0] npc);
    logic [31:0] ins, a, b, sx;
    ins  = imem_word(m_pc);
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    wr   = 1'b0;
    st   = 1'b0;
    dst  = ins[15:11];
    wd   = 32'd0;
    addr = a + sx;
    data = b;
    npc  = m_pc + 32'd4;
    case (ins[31:26])
      6'd0: begin
        wr = 1'b1;
        case (ins[5:0])
          6'd32:   wd = a + b;
          6'd34:   wd = a - b;
          6'd36:   wd = a & b;
          6'd37:   wd = a | b;
          6'd42:   wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      6'd35: begin wr = 1'b1; dst = ins[20:16]; wd = dmem_word(addr); end
      6'd43: st = 1'b1;
      6'd4:  if (a == b) npc = m_pc + 32'd4 + (sx << 2);
      6'd2:  npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int bad = -1;
    for (int r = 0; r < 32; r++)
      if (bad < 0 && dut.RegFile.file_array[r] !== m_reg[r]) bad = r;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s reg $%0d: got %h expected %h", tag, bad,
               dut.RegFile.file_array[bad], m_reg[bad]);
    end
  endtask

  task automatic check_dmem(input string tag);
    int bad = -1;
    for (int i = 0; i < int'(DMEM); i++)
      if (bad < 0 && dut.DatMem.mem_array[i] !== m_dmem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s dmem[%0d]: got %h expected %h", tag, bad,
               dut.DatMem.mem_array[bad], m_dmem[bad]);
    end
  endtask

  // Model advances in step with each DUT edge taken out of reset.
  always @(posedge clk) begin
    if (model_on && !rst) begin
      bit wr, st;
      logic [4:0] dst;
      logic [31:0] wd, addr, data, npc;
      model_eval(wr, dst, wd, st, addr, data, npc);
      if (wr && dst != 5'd0) m_reg[dst] = wd;
      if (st) for (int k = 0; k < 4; k++) m_dmem[(addr + k) % DMEM] = data[8*k +: 8];
      m_pc = npc;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      bit wr, st;
      logic [4:0] dst;
      logic [31:0] wd, addr, data, npc;
      check32("pc", dut.pc, m_pc);
      check_regs("regfile");
      check_dmem("datmem");
      model_eval(wr, dst, wd, st, addr, data, npc);
      if (wr && dst != 5'd0) check32("rfile_wd", dut.rfile_wd, wd);
    end
  end

  task automatic set_reg(input int r, input logic [31:0] v);
    dut.RegFile.file_array[r] <= v;
    m_reg[r] = (r == 0) ? 32'd0 : v;
  endtask

  task automatic set_dmem(input int a, input logic [7:0] v);
    dut.DatMem.mem_array[a] <= v;
    m_dmem[a] = v;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dut.InstrMem.mem_array[a + k] <= w[8*k +: 8];
      m_imem[a + k] = w[8*k +: 8];
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < int'(IMEM); i++) begin
      dut.InstrMem.mem_array[i] <= 8'd0;
      m_imem[i] = 8'd0;
    end
    for (int i = 0; i < int'(DMEM); i++) set_dmem(i, 8'd0);
    for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
    m_pc = 32'd0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_on = 1'b1;
  endtask

  task automatic assert_rst();
    @(negedge clk);
    #2;
    model_on = 1'b0;
    rst = 1'b1;
    m_pc = 32'd0;
  endtask

  initial begin
    // Arithmetic, $0 write, load and store.
    clear_state();
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    set_dmem(4, 8'h78); set_dmem(5, 8'h56); set_dmem(6, 8'h34); set_dmem(7, 8'h12);
    put_word(32'h00, enc_r(1, 2, 3, 32));
    put_word(32'h04, enc_r(1, 2, 4, 34));
    put_word(32'h08, enc_r(1, 2, 0, 32));
    put_word(32'h0C, enc_i(35, 0, 5, 16'd4));
    put_word(32'h10, enc_i(43, 0, 5, 16'd8));
    repeat (2) @(posedge clk);
    release_rst();
    #1;
    check32("reset_pc", dut.pc, 32'd0);
    check32("add_wd", dut.rfile_wd, 32'd8);
    @(posedge clk); #1;
    check32("sub_wd", dut.rfile_wd, 32'd2);
    repeat (7) @(posedge clk);
    #1;
    check32("add_r3", dut.RegFile.file_array[3], 32'd8);
    check32("sub_r4", dut.RegFile.file_array[4], 32'd2);
    check32("r0_zero", dut.RegFile.file_array[0], 32'd0);
    check32("lw_r5", dut.RegFile.file_array[5], 32'h12345678);
    check32("sw_word", {dut.DatMem.mem_array[11], dut.DatMem.mem_array[10],
                        dut.DatMem.mem_array[9], dut.DatMem.mem_array[8]}, 32'h12345678);

    // Jump and both branch outcomes, then asynchronous reset at pc 0x20.
    assert_rst();
    clear_state();
    set_reg(1, 32'd7);
    set_reg(2, 32'd7);
    set_reg(3, 32'd9);
    put_word(32'h08, enc_j(4));
    put_word(32'h10, enc_i(4, 1, 2, 16'd2));
    put_word(32'h1C, enc_r(2, 3, 2, 32));
    put_word(32'h20, enc_j(4));
    @(posedge clk);
    release_rst();
    #1;
    check32("b_reset_pc", dut.pc, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check32($sformatf("flow_pc%0d", i), dut.pc, pc_tab[i]);
    end
    #2;
    model_on = 1'b0;
    rst = 1'b1;
    m_pc = 32'd0;
    #1;
    check32("async_rst_pc", dut.pc, 32'd0);
    check32("rst_keep_r2", dut.RegFile.file_array[2], 32'd25);
    check_regs("rst_regs");
    @(posedge clk); #1;
    check32("rst_hold_pc", dut.pc, 32'd0);
    check_regs("rst_hold_regs");

    // Logic ops, SLT, unaligned/wrapping memory, NOPs, read-before-write.
    clear_state();
    set_reg(1, 32'hF0);
    set_reg(2, 32'h3C);
    set_reg(7, 32'hFFFF_FFFF);
    set_reg(8, 32'd1);
    set_reg(13, 32'h10);
    for (int i = 0; i < int'(DMEM); i++) set_dmem(i, 8'(i));
    put_word(32'h00, enc_r(1, 2, 3, 36));
    put_word(32'h04, enc_r(1, 2, 4, 37));
    put_word(32'h08, enc_r(1, 2, 5, 42));
    put_word(32'h0C, enc_r(7, 8, 6, 42));
    put_word(32'h10, enc_r(8, 7, 9, 42));
    put_word(32'h14, enc_i(35, 0, 11, 16'd1));
    put_word(32'h18, enc_i(35, 13, 12, 16'hFFFF));
    put_word(32'h1C, enc_i(35, 0, 14, 16'd127));
    put_word(32'h20, enc_r(1, 1, 1, 32));
    put_word(32'h24, enc_r(1, 0, 10, 32));
    put_word(32'h28, enc_i(8, 1, 15, 16'd5));
    put_word(32'h2C, enc_r(1, 2, 16, 39));
    put_word(32'h30, enc_i(43, 0, 1, 16'd126));
    put_word(32'h34, enc_r(8, 7, 17, 34));
    @(posedge clk);
    release_rst();
    repeat (15) @(posedge clk);
    #1;
    check32("and_r3", dut.RegFile.file_array[3], 32'h30);
    check32("or_r4", dut.RegFile.file_array[4], 32'hFC);
    check32("slt_r5", dut.RegFile.file_array[5], 32'd0);
    check32("slt_neg_r6", dut.RegFile.file_array[6], 32'd1);
    check32("slt_r9", dut.RegFile.file_array[9], 32'd0);
    check32("lw_unaligned", dut.RegFile.file_array[11], 32'h04030201);
    check32("lw_negoff", dut.RegFile.file_array[12], 32'h1211100F);
    check32("lw_wrap", dut.RegFile.file_array[14], 32'h0201007F);
    check32("self_add_r1", dut.RegFile.file_array[1], 32'h1E0);
    check32("after_r10", dut.RegFile.file_array[10], 32'h1E0);
    check32("nop_op_r15", dut.RegFile.file_array[15], 32'd0);
    check32("nop_fn_r16", dut.RegFile.file_array[16], 32'd0);
    check32("sub_r17", dut.RegFile.file_array[17], 32'd2);
    check32("sw_wrap", {dut.DatMem.mem_array[1], dut.DatMem.mem_array[0],
                        dut.DatMem.mem_array[127], dut.DatMem.mem_array[126]}, 32'h000001E0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
